// File: rtl/i2osp_ctrl_pkg.sv
// i2osp_ctrl_pkg: FSM state type and index-width helper shared by the I2OSP arbiter files
package i2osp_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, RESP} state_t;
  function automatic int id_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter
  import i2osp_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_idx
);
  int k;
  // scan from farthest to nearest so the request closest to ptr wins
  always_comb begin
    gnt_valid = |req;
    gnt_idx = '0;
    k = 0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      k = (int'(ptr) + j) % NUM_REQ;
      if (req[k[ID_W-1:0]]) gnt_idx = k[ID_W-1:0];
    end
  end
endmodule

// File: rtl/i2osp_arbiter.sv
// i2osp_arbiter: round-robin sharing of one I2OSP converter with clear/start, timeout and response return
module i2osp_arbiter
  import i2osp_ctrl_pkg::*;
#(
  parameter int WIDTH = 2048,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_x,
  output logic [NUM_REQ-1:0]       req_ack,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]         rsp_X,
  output logic                     rsp_err,
  output logic                     busy,
  output logic                     conv_reset,
  output logic                     conv_ready,
  output logic [WIDTH-1:0]         conv_x,
  input  logic                     conv_valid,
  input  logic [WIDTH-1:0]         conv_X
);
  localparam int ID_W = id_w(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state, state_d;
  logic [ID_W-1:0] rr_ptr, grant_q, gnt_idx;
  logic [TW-1:0] timer;
  logic gnt_valid, timed_out, grant;
  logic [NUM_REQ-1:0] ack_d, rsp_valid_d;
  logic busy_d, conv_reset_d, conv_ready_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req(req_valid),
    .ptr(rr_ptr),
    .gnt_valid(gnt_valid),
    .gnt_idx(gnt_idx)
  );

  assign timed_out = timer == TW'(TIMEOUT - 1);
  assign grant = state == IDLE && gnt_valid;

  // state register; reset aborts any in-flight operation
  always_ff @(posedge clk) state <= !reset ? IDLE : state_d;

  // next state: one grant per op, valid beats timeout, only the granted requester can complete
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    state_d = gnt_valid ? CLEAR : IDLE;
      CLEAR:   state_d = RUN;
      RUN:     state_d = (conv_valid || timed_out) ? RESP : RUN;
      RESP:    state_d = rsp_ready[grant_q] ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  // output decode from the next state so every output leaves a flop
  always_comb begin
    ack_d = grant ? NUM_REQ'(1) << gnt_idx : '0;
    rsp_valid_d = state_d == RESP ? NUM_REQ'(1) << grant_q : '0;
    busy_d = state_d != IDLE;
    conv_reset_d = state_d == CLEAR;
    conv_ready_d = state_d == RUN;
  end

  // registered outputs, operand/result capture, pointer and run timer
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr <= '0;
      grant_q <= '0;
      timer <= '0;
      conv_x <= '0;
      rsp_X <= '0;
      rsp_err <= 1'b0;
      req_ack <= '0;
      rsp_valid <= '0;
      busy <= 1'b0;
      conv_reset <= 1'b1;
      conv_ready <= 1'b0;
    end else begin
      req_ack <= ack_d;
      rsp_valid <= rsp_valid_d;
      busy <= busy_d;
      conv_reset <= conv_reset_d;
      conv_ready <= conv_ready_d;
      timer <= state == RUN ? timer + 1'b1 : '0;
      if (grant) begin
        conv_x <= req_x[gnt_idx*WIDTH +: WIDTH];
        grant_q <= gnt_idx;
        rr_ptr <= gnt_idx == ID_W'(NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
      end
      if (state == RUN && conv_valid) begin
        rsp_X <= conv_X;
        rsp_err <= 1'b0;
      end else if (state == RUN && timed_out) begin
        rsp_X <= '0;
        rsp_err <= 1'b1;
      end
    end
  end
endmodule
